// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// rf_wb_scheduler : round-robin arbiter of two writeback requesters onto the
//                   single RegFile write port, plus a RAW/WAW issue scoreboard.
// Optional: RF_WB_BYPASS_EN releases source stalls in the commit cycle.
// Revision: 1.0
// ============================================================================
module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int NREG   = 4,
  parameter int REG_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [REG_W-1:0]  issue_rs1,
  input  logic [REG_W-1:0]  issue_rs2,
  output logic              stall,
  output logic [NREG-1:0]   busy,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                reg_write_q, reg_write_d;
  logic [REG_W-1:0]    write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic                grant_a, grant_b;
  logic                rs1_hit, rs2_hit, rd_hit;

  // Gating by reset discards a commit that was captured just before reset rose.
  assign RegWrite  = reg_write_q & ~reset;
  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign busy      = reset ? '0 : busy_q;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && (!b_valid || last_grant_q == GRANT_B)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    rs1_hit = busy[issue_rs1];
    rs2_hit = busy[issue_rs2];
    rd_hit  = issue_wr && busy[issue_rd];
`ifdef RF_WB_BYPASS_EN
    // RegFile writes on the falling edge, so a same-cycle commit feeds the read.
    if (RegWrite && WriteReg == issue_rs1) rs1_hit = 1'b0;
    if (RegWrite && WriteReg == issue_rs2) rs2_hit = 1'b0;
`endif
    stall = issue_valid && (rs1_hit || rs2_hit || rd_hit);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = grant_a || grant_b;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_a) begin
      last_grant_d = GRANT_A;
      write_reg_d  = a_reg;
      write_data_d = a_data;
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
      write_reg_d  = b_reg;
      write_data_d = b_data;
    end
  end

  // Set is applied after clear so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    if (RegWrite) busy_d[WriteReg] = 1'b0;
    if (issue_valid && issue_wr && !stall) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_scheduler : directed bench; commits checked through a queue.
// Revision: 1.0
// ============================================================================
module tb_rf_wb_scheduler;

  localparam int DATA_W = 32;
  localparam int NREG   = 4;
  localparam int REG_W  = 2;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [REG_W-1:0]  a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              issue_valid, issue_wr;
  logic [REG_W-1:0]  issue_rd, issue_rs1, issue_rs2;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic              RegWrite;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] WriteData;

  int checks = 0;
  int passes = 0;
  logic [REG_W+DATA_W-1:0] exp_q[$];

  rf_wb_scheduler #(.DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .stall(stall), .busy(busy),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic wr, input logic [REG_W-1:0] rd,
                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
    issue_valid = v; issue_wr = wr; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  // Monitor: every RegWrite pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL commit_unexpected: got reg %0d data %0h expected no commit", WriteReg, WriteData);
      end else begin
        logic [REG_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("commit_reg", 32'(WriteReg), 32'(e[REG_W+DATA_W-1:DATA_W]));
        chk("commit_data", WriteData, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
    issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

    // Reset held with both requesters valid
    repeat (2) begin
      samp();
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
      chk("rst_regwrite", 32'(RegWrite), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stall", 32'(stall), 0);
      cyc();
    end
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    samp(); cyc();

    // Single write, latency 1, then hold
    a_valid = 1'b1; a_reg = 2'd2; a_data = 32'hDEADBEEF;
    samp();
    chk("single_a_ready", 32'(a_ready), 1);
    chk("single_b_ready", 32'(b_ready), 0);
    exp_q.push_back({2'd2, 32'hDEADBEEF});
    cyc();
    a_valid = 1'b0;
    samp(); cyc();
    samp();
    chk("single_n2_regwrite", 32'(RegWrite), 0);
    chk("hold_writereg", 32'(WriteReg), 2);
    chk("hold_writedata", WriteData, 32'hDEADBEEF);
    cyc();

    // Round robin straight after reset: A,B,A,B
    reset = 1'b1; samp(); cyc(); reset = 1'b0;
    a_valid = 1'b1; a_reg = 2'd1; a_data = 32'd1;
    b_valid = 1'b1; b_reg = 2'd3; b_data = 32'd3;
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) exp_q.push_back({2'd1, 32'd1});
      else            exp_q.push_back({2'd3, 32'd3});
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    samp(); cyc(); samp(); cyc();

    // RAW scoreboard on reg1
    issue(1'b1, 1'b1, 2'd1, 2'd0, 2'd0);
    samp();
    chk("sb_issue_stall", 32'(stall), 0);
    cyc();
    issue(1'b1, 1'b0, 2'd0, 2'd1, 2'd0);
    samp();
    chk("sb_busy_set", 32'(busy), 4'b0010);
    chk("sb_raw_stall", 32'(stall), 1);
    cyc();
    samp();
    chk("sb_raw_stall_hold", 32'(stall), 1);
    cyc();
    a_valid = 1'b1; a_reg = 2'd1; a_data = 32'h11;
    samp();
    chk("sb_grant_reg1", 32'(a_ready), 1);
    chk("sb_stall_pre_commit", 32'(stall), 1);
    exp_q.push_back({2'd1, 32'h11});
    cyc();
    a_valid = 1'b0;
    samp();
    chk("sb_stall_commit_cycle", 32'(stall), BYPASS ? 0 : 1);
    chk("sb_busy_commit_cycle", 32'(busy), 4'b0010);
    cyc();
    samp();
    chk("sb_busy_cleared", 32'(busy), 0);
    chk("sb_stall_released", 32'(stall), 0);
    cyc();

    // WAW on reg0, stalled issue leaves busy untouched
    issue(1'b1, 1'b1, 2'd0, 2'd3, 2'd3);
    samp(); chk("waw_first_stall", 32'(stall), 0); cyc();
    samp();
    chk("waw_busy0", 32'(busy), 4'b0001);
    chk("waw_stall", 32'(stall), 1);
    cyc();
    issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    samp(); chk("waw_no_set", 32'(busy), 4'b0001); cyc();

    // Set and clear of reg2 in the same cycle: set wins
    a_valid = 1'b1; a_reg = 2'd2; a_data = 32'h22;
    samp(); exp_q.push_back({2'd2, 32'h22}); cyc();
    a_valid = 1'b0;
    issue(1'b1, 1'b1, 2'd2, 2'd3, 2'd3);
    samp();
    chk("setclr_stall", 32'(stall), 0);
    chk("setclr_regwrite", 32'(RegWrite), 1);
    cyc();
    issue(1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    samp(); chk("setclr_busy", 32'(busy), 4'b0101); cyc();

    // Commit reg0 clears its busy bit
    a_valid = 1'b1; a_reg = 2'd0; a_data = 32'h55;
    samp(); exp_q.push_back({2'd0, 32'h55}); cyc();
    a_valid = 1'b0;
    samp(); cyc();
    samp(); chk("clr0_busy", 32'(busy), 4'b0100); cyc();

    // Reset the cycle after an A transfer: commit discarded, A wins next tie
    a_valid = 1'b1; a_reg = 2'd3; a_data = 32'h33;
    samp(); chk("rstmid_grant", 32'(a_ready), 1); cyc();
    a_valid = 1'b0; reset = 1'b1;
    samp();
    chk("rstmid_regwrite", 32'(RegWrite), 0);
    chk("rstmid_busy", 32'(busy), 0);
    cyc();
    reset = 1'b0;
    a_valid = 1'b1; a_reg = 2'd0; a_data = 32'hAA;
    b_valid = 1'b1; b_reg = 2'd1; b_data = 32'hBB;
    samp();
    chk("rstmid_after_regwrite", 32'(RegWrite), 0);
    chk("rstmid_after_busy", 32'(busy), 0);
    chk("rstmid_tie_a", 32'(a_ready), 1);
    chk("rstmid_tie_b", 32'(b_ready), 0);
    exp_q.push_back({2'd0, 32'hAA});
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    samp(); cyc(); samp(); cyc();

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
